jt10_acc_sched: RTL and testbench
=================================

Name: jt10_acc_sched

Overview:
Slot scheduler and input arbiter for the YM2610 stereo accumulator pair. It generates the 24-slot operator sequence (cur_ch, cur_op, zero) and shares the accumulator input between FM operator data and the ADPCM-A and ADPCM-B sample streams. ADPCM samples arrive asynchronously to the frame. They are double-buffered and injected at fixed slots. The block sits between the operator pipeline/ADPCM engines and the two single-channel accumulators.

Parameters:
STALE_FRAMES, 8, consecutive frames without a new sample after which a source is muted (1..15)
SLOTS, 24, slots per frame; fixed, must equal 6 channels x 4 operators

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
clk_en  in  1  slot advance enable; all state except ADPCM capture is gated by it
op_result  in  14  signed FM operator output, aligned with current cur_ch/cur_op
rl  in  2  channel pan for current slot: [1]=left, [0]=right
fm_sum_en  in  1  algorithm-derived sum enable for current slot
adpcmA_l, adpcmA_r  in  16  signed ADPCM-A sample
adpcmA_valid  in  1  one-clk strobe, ADPCM-A sample present
adpcmB_l, adpcmB_r  in  16  signed ADPCM-B sample
adpcmB_valid  in  1  one-clk strobe, ADPCM-B sample present
mix_en  in  1  1 = ADPCM injection enabled; 0 = FM on all slots
ovf_clr  in  1  clears sticky overflow flags
cur_ch  out  3  channel of current slot: 0,1,2,4,5,6
cur_op  out  2  operator of current slot
zero  out  1  high on last slot of frame
acc_input_l, acc_input_r  out  16  accumulator operands (registered)
acc_en_l, acc_en_r  out  1  accumulator sum enables (registered)
ovfA, ovfB  out  1  sticky: sample overwritten before commit
staleA, staleB  out  1  source muted for staleness

Behaviour:
- Reset (async, rst_n=0): slot=0, cur_ch=0, cur_op=0, zero=0, acc_input_*=0, acc_en_*=0. Pending and active buffers are 0. pendA/pendB=0, ovf*=0. Stale counters=STALE_FRAMES and stale*=1. Reset mid-frame restarts the frame at slot 0.
- Slot counter: 0..23, advances on clk_en and wraps 23->0. chidx=slot mod 6 maps to cur_ch {0,1,2,4,5,6}; cur_op=slot/6. cur_ch, cur_op and zero are decoded from registered slot. zero=1 iff slot==23.
- Capture (every clk, not gated by clk_en): on X_valid, load pending X registers. If pendX is already 1, set ovfX, else set pendX.
- ovf_clr and a new overflow in the same cycle: set wins.
- Commit: on a clk_en cycle with zero=1, for each source with pendX=1: active<=pending, pendX<=0, stale counter<=0, staleX<=0.
- Commit when there is no pending sample: the stale counter increments and saturates at STALE_FRAMES. staleX=1 when the counter equals STALE_FRAMES.
- Valid in the same cycle as commit: the old pending value commits, the new sample becomes pending, pendX stays 1, and no overflow is flagged.
- Operand select, registered on clk_en with 1 clk_en latency from slot:
  - slot (op0,ch0) and mix_en: ADPCM-A. Operand is active_A x 6, saturated to [-32768,32767]. acc_en_l = acc_en_r = ~staleA; operand is 0 when stale.
  - slot (op0,ch4) and mix_en: ADPCM-B. Operand is active_B >>> 1. acc_en_l = acc_en_r = ~staleB.
  - All other slots, or mix_en=0: FM. Operand is sign-extended op_result >>> 1. acc_en_l = fm_sum_en & rl[1]; acc_en_r = fm_sum_en & rl[0].
- clk_en=0: all registered outputs hold.

Test Plan:
- Reset release, clk_en always 1 -> cur_ch/cur_op sequence 0,1,2,4,5,6 x op 0..3; zero high only on slot 23 (op3,ch6); slot 24 wraps to (0,0).
- op_result=14'h1FFF, rl=2'b10, fm_sum_en=1, mix_en=0 -> acc_input_l=16'h0FFF, acc_en_l=1, acc_en_r=0, one clk_en later.
- mix_en=1, adpcmA_l=16'h1000 strobed mid-frame -> next frame's (op0,ch0) slot gives acc_input_l=16'h6000 with acc_en_l=1. adpcmA_l=16'h2000 -> saturates to 16'h7FFF. adpcmA_l=16'hC000 -> 16'h8000.
- Two adpcmB_valid strobes in one frame (values 16'h0100 then 16'h0200) -> ovfB=1. ADPCM-B slot gives 16'h0100 (second value >>> 1). ovf_clr pulse -> ovfB=0.
- No adpcmA_valid for 8 frames after a commit -> staleA=1 at the 8th boundary. ADPCM-A slot then gives acc_en_l=acc_en_r=0, operand 0. The next strobe and commit clears staleA.
- adpcmA_valid coincident with the zero/clk_en commit cycle while pendA=1 -> old value active, new value pending, ovfA stays 0. Asserting rst_n=0 mid-frame -> outputs 0 immediately, asynchronously.

Source files
------------

// File: rtl/jt10_acc_sched.sv
// rtl/jt10_acc_sched.sv - YM2610 accumulator slot scheduler and FM/ADPCM input arbiter
//
// Generates the 24-slot operator sequence and selects, per slot, the operand fed to the
// left/right accumulators: FM operator data, or double-buffered ADPCM-A/ADPCM-B samples
// injected at fixed slots.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   clk_en                  slot advance enable (gates everything except ADPCM capture)
//   op_result, rl, fm_sum_en FM operand, pan and sum enable for the current slot
//   adpcmA_*, adpcmB_*      ADPCM sample pairs with one-clk valid strobes
//   mix_en                  enable ADPCM injection at its slots
//   ovf_clr                 clears the sticky overflow flags
//   cur_ch, cur_op, zero    decoded slot sequence, zero marks the last slot of a frame
//   acc_input_*, acc_en_*   registered accumulator operands and sum enables
//   ovfA/B, staleA/B        overwrite-before-commit and muted-for-staleness status

module jt10_acc_sched #(
  parameter int STALE_FRAMES = 8,
  parameter int SLOTS        = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clk_en,
  input  logic [13:0] op_result,
  input  logic [1:0]  rl,
  input  logic        fm_sum_en,
  input  logic [15:0] adpcmA_l,
  input  logic [15:0] adpcmA_r,
  input  logic        adpcmA_valid,
  input  logic [15:0] adpcmB_l,
  input  logic [15:0] adpcmB_r,
  input  logic        adpcmB_valid,
  input  logic        mix_en,
  input  logic        ovf_clr,
  output logic [2:0]  cur_ch,
  output logic [1:0]  cur_op,
  output logic        zero,
  output logic [15:0] acc_input_l,
  output logic [15:0] acc_input_r,
  output logic        acc_en_l,
  output logic        acc_en_r,
  output logic        ovfA,
  output logic        ovfB,
  output logic        staleA,
  output logic        staleB
);

  localparam logic [4:0] LAST_SLOT = 5'(SLOTS - 1);
  localparam logic [3:0] STALE_CNT = 4'(STALE_FRAMES);

  logic [4:0] slot;
  logic [2:0] chidx;
  logic       commit;

  // Index 0 is ADPCM-A, index 1 is ADPCM-B.
  logic [1:0]       vld;
  logic [1:0][15:0] smp_l, smp_r;
  logic [1:0][15:0] pend_l, pend_r;
  logic [1:0][15:0] act_l, act_r;
  logic [1:0]       pend;
  logic [1:0]       ovf;
  logic [1:0][3:0]  cnt;
  logic [1:0]       stale;

  assign vld   = {adpcmB_valid, adpcmA_valid};
  assign smp_l = {adpcmB_l, adpcmA_l};
  assign smp_r = {adpcmB_r, adpcmA_r};

  // Slot decode: operator = slot/6, channel index = slot mod 6, with channel 3 skipped.
  always_comb begin
    cur_op = 2'd0;
    chidx  = 3'(slot);
    if (slot >= 5'd18) begin
      cur_op = 2'd3;
      chidx  = 3'(slot - 5'd18);
    end else if (slot >= 5'd12) begin
      cur_op = 2'd2;
      chidx  = 3'(slot - 5'd12);
    end else if (slot >= 5'd6) begin
      cur_op = 2'd1;
      chidx  = 3'(slot - 5'd6);
    end
  end

  assign cur_ch = (chidx >= 3'd3) ? chidx + 3'd1 : chidx;
  assign zero   = (slot == LAST_SLOT);
  assign commit = clk_en & zero;

  assign stale[0] = (cnt[0] == STALE_CNT);
  assign stale[1] = (cnt[1] == STALE_CNT);

  assign ovfA   = ovf[0];
  assign ovfB   = ovf[1];
  assign staleA = stale[0];
  assign staleB = stale[1];

  // ADPCM-A gain of 6, clipped to the 16-bit accumulator operand range.
  function automatic logic [15:0] sat_x6(input logic [15:0] s);
    logic signed [18:0] e;
    logic signed [18:0] p;
    e = {{3{s[15]}}, s};
    p = (e <<< 2) + (e <<< 1);
    if (p > 19'sd32767)
      return 16'h7FFF;
    else if (p < -19'sd32768)
      return 16'h8000;
    else
      return p[15:0];
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot <= 5'd0;
    end else if (clk_en) begin
      slot <= (slot == LAST_SLOT) ? 5'd0 : slot + 5'd1;
    end
  end

  // Sample buffers. Capture runs every clock because ADPCM strobes are not aligned to
  // clk_en; commit into the active buffers happens only at the frame boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_l <= '0;
      pend_r <= '0;
      act_l  <= '0;
      act_r  <= '0;
      pend   <= '0;
      ovf    <= '0;
      cnt    <= {STALE_CNT, STALE_CNT};
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (vld[i]) begin
          pend_l[i] <= smp_l[i];
          pend_r[i] <= smp_r[i];
        end
        if (commit && pend[i]) begin
          act_l[i] <= pend_l[i];
          act_r[i] <= pend_r[i];
          cnt[i]   <= 4'd0;
          // A strobe landing on the commit cycle refills the just-emptied buffer.
          pend[i]  <= vld[i];
        end else begin
          if (commit && (cnt[i] != STALE_CNT))
            cnt[i] <= cnt[i] + 4'd1;
          if (vld[i])
            pend[i] <= 1'b1;
        end
        // A new overwrite has priority over a clear in the same cycle.
        if (vld[i] && pend[i] && !commit)
          ovf[i] <= 1'b1;
        else if (ovf_clr)
          ovf[i] <= 1'b0;
      end
    end
  end

  // Operand select, one clk_en behind the slot it belongs to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_input_l <= 16'd0;
      acc_input_r <= 16'd0;
      acc_en_l    <= 1'b0;
      acc_en_r    <= 1'b0;
    end else if (clk_en) begin
      if (mix_en && (slot == 5'd0)) begin
        acc_input_l <= stale[0] ? 16'd0 : sat_x6(act_l[0]);
        acc_input_r <= stale[0] ? 16'd0 : sat_x6(act_r[0]);
        acc_en_l    <= ~stale[0];
        acc_en_r    <= ~stale[0];
      end else if (mix_en && (slot == 5'd3)) begin
        acc_input_l <= {act_l[1][15], act_l[1][15:1]};
        acc_input_r <= {act_r[1][15], act_r[1][15:1]};
        acc_en_l    <= ~stale[1];
        acc_en_r    <= ~stale[1];
      end else begin
        acc_input_l <= {{3{op_result[13]}}, op_result[13:1]};
        acc_input_r <= {{3{op_result[13]}}, op_result[13:1]};
        acc_en_l    <= fm_sum_en & rl[1];
        acc_en_r    <= fm_sum_en & rl[0];
      end
    end
  end

endmodule

// File: tb/tb_jt10_acc_sched.sv
// tb/tb_jt10_acc_sched.sv - self-checking bench for jt10_acc_sched with a frame-level reference model

module tb_jt10_acc_sched;
  localparam int STALE = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clk_en = 1'b0;
  logic [13:0] op_result = '0;
  logic [1:0]  rl = '0;
  logic        fm_sum_en = 1'b0;
  logic [15:0] a_l = '0, a_r = '0, b_l = '0, b_r = '0;
  logic        a_v = 1'b0, b_v = 1'b0;
  logic        mix_en = 1'b0;
  logic        ovf_clr = 1'b0;

  logic [2:0]  cur_ch;
  logic [1:0]  cur_op;
  logic        zero;
  logic [15:0] acc_input_l, acc_input_r;
  logic        acc_en_l, acc_en_r;
  logic        ovfA, ovfB, staleA, staleB;

  jt10_acc_sched #(.STALE_FRAMES(STALE), .SLOTS(24)) dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en),
    .op_result(op_result), .rl(rl), .fm_sum_en(fm_sum_en),
    .adpcmA_l(a_l), .adpcmA_r(a_r), .adpcmA_valid(a_v),
    .adpcmB_l(b_l), .adpcmB_r(b_r), .adpcmB_valid(b_v),
    .mix_en(mix_en), .ovf_clr(ovf_clr),
    .cur_ch(cur_ch), .cur_op(cur_op), .zero(zero),
    .acc_input_l(acc_input_l), .acc_input_r(acc_input_r),
    .acc_en_l(acc_en_l), .acc_en_r(acc_en_r),
    .ovfA(ovfA), .ovfB(ovfB), .staleA(staleA), .staleB(staleB)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: slot number, per-source buffers as plain integers.
  int m_slot;
  int pv_l[2], pv_r[2], ac_l[2], ac_r[2];
  bit m_pend[2], m_ovf[2];
  int m_cnt[2];
  int e_in_l, e_in_r;
  bit e_en_l, e_en_r;

  function automatic int sat6(input int v);
    int p;
    p = v * 6;
    if (p > 32767) return 32767;
    if (p < -32768) return -32768;
    return p;
  endfunction

  function automatic int chmap(input int i);
    case (i)
      0: return 0;
      1: return 1;
      2: return 2;
      3: return 4;
      4: return 5;
      default: return 6;
    endcase
  endfunction

  task automatic model_reset();
    m_slot = 0;
    for (int s = 0; s < 2; s++) begin
      pv_l[s] = 0; pv_r[s] = 0; ac_l[s] = 0; ac_r[s] = 0;
      m_pend[s] = 0; m_ovf[s] = 0; m_cnt[s] = STALE;
    end
    e_in_l = 0; e_in_r = 0; e_en_l = 0; e_en_r = 0;
  endtask

  task automatic model_step();
    bit vld[2];
    int sl[2], sr[2];
    bit commit;
    int fm;
    vld[0] = a_v; vld[1] = b_v;
    sl[0] = $signed(a_l); sr[0] = $signed(a_r);
    sl[1] = $signed(b_l); sr[1] = $signed(b_r);
    commit = clk_en && (m_slot == 23);
    if (clk_en) begin
      if (mix_en && m_slot == 0) begin
        bit st;
        st = (m_cnt[0] == STALE);
        e_in_l = st ? 0 : sat6(ac_l[0]);
        e_in_r = st ? 0 : sat6(ac_r[0]);
        e_en_l = !st; e_en_r = !st;
      end else if (mix_en && m_slot == 3) begin
        e_in_l = ac_l[1] >>> 1;
        e_in_r = ac_r[1] >>> 1;
        e_en_l = (m_cnt[1] != STALE); e_en_r = (m_cnt[1] != STALE);
      end else begin
        fm = $signed(op_result);
        e_in_l = fm >>> 1; e_in_r = fm >>> 1;
        e_en_l = fm_sum_en && rl[1]; e_en_r = fm_sum_en && rl[0];
      end
    end
    for (int s = 0; s < 2; s++) begin
      if (vld[s] && m_pend[s] && !commit) m_ovf[s] = 1;
      else if (ovf_clr) m_ovf[s] = 0;
      if (commit && m_pend[s]) begin
        ac_l[s] = pv_l[s]; ac_r[s] = pv_r[s];
        m_cnt[s] = 0;
        m_pend[s] = vld[s];
      end else begin
        if (commit && m_cnt[s] < STALE) m_cnt[s]++;
        if (vld[s]) m_pend[s] = 1;
      end
      if (vld[s]) begin pv_l[s] = sl[s]; pv_r[s] = sr[s]; end
    end
    if (clk_en) m_slot = (m_slot + 1) % 24;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("cur_ch", cur_ch, chmap(m_slot % 6));
    chk("cur_op", cur_op, m_slot / 6);
    chk("zero", zero, m_slot == 23);
    chk("acc_input_l", $signed(acc_input_l), e_in_l);
    chk("acc_input_r", $signed(acc_input_r), e_in_r);
    chk("acc_en_l", acc_en_l, e_en_l);
    chk("acc_en_r", acc_en_r, e_en_r);
    chk("ovfA", ovfA, m_ovf[0]);
    chk("ovfB", ovfB, m_ovf[1]);
    chk("staleA", staleA, m_cnt[0] == STALE);
    chk("staleB", staleB, m_cnt[1] == STALE);
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step();
    #1;
    check_all();
  endtask

  task automatic run_to(input int s);
    clk_en = 1'b1;
    while (m_slot != s) tick();
  endtask

  task automatic strobe_a(input logic [15:0] l, input logic [15:0] r);
    a_l = l; a_r = r; a_v = 1'b1;
    tick();
    a_v = 1'b0;
  endtask

  task automatic strobe_b(input logic [15:0] l, input logic [15:0] r);
    b_l = l; b_r = r; b_v = 1'b1;
    tick();
    b_v = 1'b0;
  endtask

  initial begin
    model_reset();
    #12;
    chk("rst_cur_ch", cur_ch, 0);
    chk("rst_zero", zero, 0);
    chk("rst_acc_l", acc_input_l, 0);
    chk("rst_staleA", staleA, 1);
    check_all();

    // Release reset, walk slightly more than one frame with FM only.
    @(posedge clk); #1;
    rst_n = 1'b1; clk_en = 1'b1;
    for (int k = 0; k < 26; k++) begin
      op_result = 14'($urandom); rl = 2'($urandom); fm_sum_en = 1'($urandom);
      tick();
    end

    // FM operand path.
    op_result = 14'h1FFF; rl = 2'b10; fm_sum_en = 1'b1;
    tick();
    chk("fm_l_1fff", acc_input_l, 16'h0FFF);
    chk("fm_en_l", acc_en_l, 1);
    chk("fm_en_r", acc_en_r, 0);

    // ADPCM-A gain and saturation.
    mix_en = 1'b1;
    run_to(10); strobe_a(16'h1000, 16'h0800);
    run_to(0); tick();
    chk("a_x6_l", acc_input_l, 16'h6000);
    chk("a_x6_r", acc_input_r, 16'h3000);
    chk("a_x6_en", acc_en_l, 1);
    run_to(10); strobe_a(16'h2000, 16'hC000);
    run_to(0); tick();
    chk("a_sat_pos", acc_input_l, 32767);
    chk("a_sat_neg", $signed(acc_input_r), -32768);

    // ADPCM-B overwrite, shift and overflow clear.
    run_to(5); strobe_b(16'h0100, 16'h0000);
    run_to(8); strobe_b(16'h0200, 16'hFE00);
    chk("b_ovf_set", ovfB, 1);
    run_to(3); tick();
    chk("b_shift_l", acc_input_l, 16'h0100);
    chk("b_shift_r", $signed(acc_input_r), -256);
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    chk("b_ovf_clr", ovfB, 0);

    // Staleness after eight boundaries without a new sample.
    run_to(10); strobe_a(16'h0010, 16'h0000);
    run_to(23); tick();
    chk("stale_fresh", staleA, 0);
    for (int f = 1; f <= 8; f++) begin
      run_to(23); tick();
      chk("stale_count", staleA, f == 8);
    end
    run_to(0); tick();
    chk("stale_en_l", acc_en_l, 0);
    chk("stale_en_r", acc_en_r, 0);
    chk("stale_zero_op", acc_input_l, 0);
    run_to(10); strobe_a(16'h0020, 16'h0000);
    run_to(23); tick();
    chk("stale_cleared", staleA, 0);

    // Strobe coinciding with the commit cycle.
    run_to(10); strobe_a(16'h0040, 16'h0000);
    run_to(23);
    a_l = 16'h0080; a_v = 1'b1; tick(); a_v = 1'b0;
    chk("coinc_no_ovf", ovfA, 0);
    tick();
    chk("coinc_old", acc_input_l, 384);
    run_to(23); tick(); tick();
    chk("coinc_new", acc_input_l, 768);

    // Randomized traffic, including captures while clk_en is low.
    for (int k = 0; k < 1500; k++) begin
      clk_en    = ($urandom_range(3) != 0);
      op_result = 14'($urandom); rl = 2'($urandom); fm_sum_en = 1'($urandom);
      a_v = ($urandom_range(19) == 0); a_l = 16'($urandom); a_r = 16'($urandom);
      b_v = ($urandom_range(19) == 0); b_l = 16'($urandom); b_r = 16'($urandom);
      if ($urandom_range(1) == 0) begin a_l = a_l >>> 3; b_l = b_l >>> 3; end
      mix_en  = ($urandom_range(7) != 0);
      ovf_clr = ($urandom_range(29) == 0);
      tick();
    end
    a_v = 1'b0; b_v = 1'b0; ovf_clr = 1'b0;

    // Asynchronous reset mid-frame.
    mix_en = 1'b0; op_result = 14'h0123; rl = 2'b11; fm_sum_en = 1'b1;
    run_to(7); tick();
    rst_n = 1'b0;
    #1;
    chk("async_cur_ch", cur_ch, 0);
    chk("async_cur_op", cur_op, 0);
    chk("async_acc_l", acc_input_l, 0);
    chk("async_en_l", acc_en_l, 0);
    chk("async_staleA", staleA, 1);
    model_reset();
    tick(); tick();
    rst_n = 1'b1;
    mix_en = 1'b1;
    for (int k = 0; k < 30; k++) begin
      op_result = 14'($urandom);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
